// File: rtl/imem_loader.sv
// Instruction memory loader: packs a little-endian byte stream into 32-bit words,
// writes them from address 0 upward and holds the core in reset while loading.
module imem_loader #(
    parameter int unsigned AW = 8,
    localparam int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   num_words,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic          abort,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] chksum
);

    localparam logic [AW:0] CAPACITY = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [AW:0]   word_cnt_q, word_cnt_d;
    logic [AW:0]   num_words_q, num_words_d;
    logic [23:0]   word_buf_q, word_buf_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_waddr_q, mem_waddr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [DW-1:0] chksum_q, chksum_d;
    logic [AW:0]   word_cnt_inc;
    logic [DW-1:0] full_word;

    // Ready depends on state alone so the sender never sees a combinational loop.
    assign byte_ready = (state_q == RECV);

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        num_words_d  = num_words_q;
        word_buf_d   = word_buf_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        err_d        = 1'b0;
        chksum_d     = chksum_q;
        word_cnt_inc = word_cnt_q + (AW+1)'(1);
        full_word    = {byte_data, word_buf_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words > CAPACITY) begin
                        err_d = 1'b1;
                    end else begin
                        num_words_d = num_words;
                        chksum_d    = '0;
                        byte_cnt_d  = '0;
                        word_cnt_d  = '0;
                        state_d     = (num_words == '0) ? DONE : RECV;
                    end
                end
            end
            RECV: begin
                if (abort) begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    byte_cnt_d = '0;
                end else if (byte_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: word_buf_d[7:0]   = byte_data;
                        2'd1: word_buf_d[15:8]  = byte_data;
                        2'd2: word_buf_d[23:16] = byte_data;
                        default: begin
                            // Write outputs are registered, so they are loaded on entry to WRITE.
                            state_d     = WRITE;
                            mem_we_d    = 1'b1;
                            mem_waddr_d = word_cnt_q[AW-1:0];
                            mem_wdata_d = full_word;
                            chksum_d    = chksum_q + full_word;
                        end
                    endcase
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_inc;
                if (abort) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = (word_cnt_inc == num_words_q) ? DONE : RECV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_rst_d = (state_d != IDLE);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            num_words_q <= '0;
            word_buf_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            chksum_q    <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            num_words_q <= num_words_d;
            word_buf_q  <= word_buf_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            chksum_q    <= chksum_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign chksum    = chksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table for the basic load,
// then hand-written sequences for throttling, boundaries, abort and reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid, abort;
    logic [8:0]  num_words;
    logic [7:0]  byte_data;
    logic        byte_ready, mem_we, cpu_rst, busy, done, err;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata, chksum;

    imem_loader #(.AW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .abort(abort), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err), .chksum(chksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic        we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic        cpu_rst;
        logic        busy;
        logic        done;
        logic        err;
        logic [31:0] chksum;
    } outs_t;

    typedef struct {
        logic       start;
        logic [8:0] nw;
        logic       valid;
        logic [7:0] data;
        outs_t      exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  img [0:1023];
    logic [7:0]  log_addr [$];
    logic [31:0] log_data [$];
    int          done_cnt = 0;
    int          err_cnt  = 0;

    // Write/pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            log_addr.push_back(mem_waddr);
            log_data.push_back(mem_wdata);
        end
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.ready   = byte_ready;
        o.we      = mem_we;
        o.waddr   = mem_we ? mem_waddr : 8'h00;
        o.wdata   = mem_we ? mem_wdata : 32'h0;
        o.cpu_rst = cpu_rst;
        o.busy    = busy;
        o.done    = done;
        o.err     = err;
        o.chksum  = chksum;
        return o;
    endfunction

    function automatic vec_t mk(input logic s, input logic [8:0] nw, input logic v,
                                input logic [7:0] d, input logic rdy, input logic we,
                                input logic [7:0] wa, input logic [31:0] wd,
                                input logic cr, input logic dn, input logic [31:0] ck);
        vec_t t;
        t.start = s; t.nw = nw; t.valid = v; t.data = d;
        t.exp = '{ready: rdy, we: we, waddr: wa, wdata: wd, cpu_rst: cr, busy: cr,
                  done: dn, err: 1'b0, chksum: ck};
        return t;
    endfunction

    function automatic logic [31:0] word_of(input int i);
        return 32'(i) * 32'h0100_0193 + 32'h0000_1234;
    endfunction

    task automatic do_start(input logic [8:0] nw);
        start = 1'b1;
        num_words = nw;
        step();
        start = 1'b0;
    endtask

    // Streams img[first .. first+n-1]; thr inserts two idle cycles after each accepted byte.
    task automatic feed(input int first, input int n, input bit thr);
        int  idx = first;
        int  gap = 0;
        int  cyc = 0;
        bit  hold = 1'b0;
        bit  acc;
        while (idx < first + n && cyc < n * 8 + 20) begin
            if (hold) byte_valid = 1'b1;
            else if (gap > 0) begin gap--; byte_valid = 1'b0; end
            else byte_valid = 1'b1;
            byte_data = img[idx];
            #1;
            acc = byte_valid && byte_ready;
            step();
            cyc++;
            if (acc) begin idx++; hold = 1'b0; gap = thr ? 2 : 0; end
            else hold = byte_valid;
        end
        byte_valid = 1'b0;
        check("feed_complete", 96'(idx), 96'(first + n));
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            step();
            cycles++;
        end
        check("done_reached", 96'(done), 96'(1));
    endtask

    vec_t tv [13];

    initial begin
        int base, dbase, ebase, cyc, errs;
        logic [31:0] sum;

        rst = 1'b1; start = 1'b0; num_words = '0; byte_valid = 1'b0;
        byte_data = '0; abort = 1'b0;
        img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'hA0; img[3] = 8'h00;
        img[4] = 8'h93; img[5] = 8'h85; img[6] = 8'h15; img[7] = 8'h00;

        tv[0]  = mk(1, 9'd2, 0, 8'h00, 0, 0, 8'h00, 32'h0,          0, 0, 32'h0);
        tv[1]  = mk(0, 9'd0, 1, 8'h13, 1, 0, 8'h00, 32'h0,          1, 0, 32'h0);
        tv[2]  = mk(0, 9'd0, 1, 8'h05, 1, 0, 8'h00, 32'h0,          1, 0, 32'h0);
        tv[3]  = mk(0, 9'd0, 1, 8'hA0, 1, 0, 8'h00, 32'h0,          1, 0, 32'h0);
        tv[4]  = mk(0, 9'd0, 1, 8'h00, 1, 0, 8'h00, 32'h0,          1, 0, 32'h0);
        tv[5]  = mk(0, 9'd0, 1, 8'h93, 0, 1, 8'h00, 32'h00A0_0513,  1, 0, 32'h00A0_0513);
        tv[6]  = mk(0, 9'd0, 1, 8'h93, 1, 0, 8'h00, 32'h0,          1, 0, 32'h00A0_0513);
        tv[7]  = mk(0, 9'd0, 1, 8'h85, 1, 0, 8'h00, 32'h0,          1, 0, 32'h00A0_0513);
        tv[8]  = mk(0, 9'd0, 1, 8'h15, 1, 0, 8'h00, 32'h0,          1, 0, 32'h00A0_0513);
        tv[9]  = mk(0, 9'd0, 1, 8'h00, 1, 0, 8'h00, 32'h0,          1, 0, 32'h00A0_0513);
        tv[10] = mk(0, 9'd0, 0, 8'h00, 0, 1, 8'h01, 32'h0015_8593,  1, 0, 32'h00B5_8AA6);
        tv[11] = mk(0, 9'd0, 0, 8'h00, 0, 0, 8'h00, 32'h0,          1, 1, 32'h00B5_8AA6);
        tv[12] = mk(0, 9'd0, 0, 8'h00, 0, 0, 8'h00, 32'h0,          0, 0, 32'h00B5_8AA6);

        step(); step();
        rst = 1'b0;

        // Normal load, cycle by cycle; row 0 also covers the post-reset state.
        for (int i = 0; i < 13; i++) begin
            start = tv[i].start; num_words = tv[i].nw;
            byte_valid = tv[i].valid; byte_data = tv[i].data;
            #1;
            check($sformatf("table_row%0d", i), 96'(sample()), 96'(tv[i].exp));
            step();
        end
        start = 1'b0; byte_valid = 1'b0;

        // Throttled stream of the same image.
        base = log_addr.size(); dbase = done_cnt;
        do_start(9'd2);
        feed(0, 8, 1'b1);
        wait_done(10, cyc);
        check("thr_done_latency", 96'(cyc), 96'(1));
        check("thr_writes", 96'(log_addr.size() - base), 96'(2));
        check("thr_w0", {log_addr[base], log_data[base]}, {8'h00, 32'h00A0_0513});
        check("thr_w1", {log_addr[base+1], log_data[base+1]}, {8'h01, 32'h0015_8593});
        check("thr_chksum", 96'(chksum), 96'(32'h00B5_8AA6));
        check("thr_cpu_rst_done", 96'(cpu_rst), 96'(1));
        step();
        check("thr_cpu_rst_after", 96'(cpu_rst), 96'(0));
        check("thr_done_count", 96'(done_cnt - dbase), 96'(1));

        // Zero-length image.
        base = log_addr.size();
        do_start(9'd0);
        check("zero_done", {done, chksum}, {1'b1, 32'h0});
        step();
        check("zero_after", {done, busy, 8'(log_addr.size() - base)}, {1'b0, 1'b0, 8'h00});

        // Oversized image is rejected.
        ebase = err_cnt;
        do_start(9'd257);
        check("over_err", {err, busy, cpu_rst, byte_ready}, {1'b1, 1'b0, 1'b0, 1'b0});
        step();
        check("over_idle", {err, busy, byte_ready}, {1'b0, 1'b0, 1'b0});
        check("over_err_count", 96'(err_cnt - ebase), 96'(1));

        // Full memory: 256 words.
        sum = '0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = word_of(i);
            sum += w;
            img[4*i] = w[7:0]; img[4*i+1] = w[15:8]; img[4*i+2] = w[23:16]; img[4*i+3] = w[31:24];
        end
        base = log_addr.size();
        do_start(9'd256);
        feed(0, 1024, 1'b0);
        wait_done(10, cyc);
        check("full_writes", 96'(log_addr.size() - base), 96'(256));
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (log_addr[base+i] !== 8'(i) || log_data[base+i] !== word_of(i)) errs++;
        check("full_log_errs", 96'(errs), 96'(0));
        check("full_last_addr", 96'(log_addr[base+255]), 96'(8'hFF));
        check("full_chksum", 96'(chksum), 96'(sum));
        step();

        // Abort after one word plus two bytes, then reload from address 0.
        base = log_addr.size(); dbase = done_cnt; ebase = err_cnt;
        do_start(9'd3);
        feed(0, 6, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_resp", {err, busy, cpu_rst, byte_ready}, {1'b1, 1'b0, 1'b0, 1'b0});
        step(); step();
        check("abort_counts", {8'(log_addr.size() - base), 8'(done_cnt - dbase), 8'(err_cnt - ebase)},
              {8'd1, 8'd0, 8'd1});
        check("abort_w0", {log_addr[base], log_data[base]}, {8'h00, word_of(0)});
        base = log_addr.size();
        do_start(9'd1);
        feed(100, 4, 1'b0);
        wait_done(10, cyc);
        check("reload_w0", {8'(log_addr.size() - base), log_addr[base], log_data[base]},
              {8'd1, 8'h00, word_of(25)});
        check("reload_chksum", 96'(chksum), 96'(word_of(25)));
        step();

        // Reset while the WRITE cycle is active.
        ebase = err_cnt;
        do_start(9'd2);
        feed(0, 4, 1'b0);
        check("rst_in_write", 96'(mem_we), 96'(1));
        rst = 1'b1; abort = 1'b1;
        step();
        rst = 1'b0; abort = 1'b0;
        check("rst_outputs", 96'({byte_ready, mem_we, mem_waddr, mem_wdata, cpu_rst, busy, done, err, chksum}),
              96'(0));
        step(); step();
        check("rst_no_err", 96'(err_cnt - ebase), 96'(0));

        // start during RECV is ignored; the latched count of 2 still applies.
        base = log_addr.size(); ebase = err_cnt;
        do_start(9'd2);
        feed(0, 2, 1'b0);
        start = 1'b1; num_words = 9'd1;
        step();
        start = 1'b0;
        feed(2, 6, 1'b0);
        wait_done(10, cyc);
        check("busy_start_writes", {8'(log_addr.size() - base), 8'(err_cnt - ebase)}, {8'd2, 8'd0});
        check("busy_start_w1", {log_addr[base+1], log_data[base+1]}, {8'h01, word_of(1)});
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
